// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM encoding,
// hex segment codes ({a,b,c,d,e,f,g,dp} = [7:0]) and idle output levels.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [3:0] COM_OFF = 4'b1111;

  // Element i is the active-high code for hex digit i; dp bit is left clear.
  localparam logic [15:0][7:0] SEG_CODE = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to seven-segment decoder, {a..g} on seg[6:0].
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = SEG_CODE[digit];
    seg  = code[7:1];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with a double-buffered display
// value loaded at frame boundaries and optional leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic        clk_1k,
  input  logic        resetn,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic        blank_lz,
  output logic [3:0]  seg_com,
  output logic [7:0]  seg_data,
  output logic        frame_done
);

  localparam int CMAX  = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W = $clog2(CMAX + 1);

  state_t           state, state_nx;
  logic [1:0]       idx, idx_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic [15:0] disp, disp_nx, pend;
  logic [3:0]  dp, dp_nx, pend_dp;
  logic        pend_full;
  logic        boundary;

  logic [3:0]  com_nx;
  logic [7:0]  data_nx;
  logic        fd_nx;
  logic [3:0]  nibble;
  logic [6:0]  seg_a2g;
  logic        lz;

  // Last cycle of digit 3 closes the frame: final GAP cycle, or final SHOW
  // cycle when there is no gap.
  function automatic logic is_last(state_t s, logic [1:0] i, logic [CNT_W-1:0] c);
    if (i != 2'd3) return 1'b0;
    if (BLANK > 0) return (s == ST_GAP) && (int'(c) == BLANK - 1);
    return (s == ST_SHOW) && (int'(c) == DWELL - 1);
  endfunction

  always_ff @(posedge clk_1k or negedge resetn) begin
    if (!resetn) begin
      state <= ST_RST;
      idx   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt + 1'b1;
    case (state)
      ST_RST: begin
        state_nx = ST_SHOW;
        idx_nx   = 2'd0;
        cnt_nx   = '0;
      end
      ST_SHOW: begin
        if (int'(cnt) == DWELL - 1) begin
          cnt_nx = '0;
          if (BLANK > 0) state_nx = ST_GAP;
          else           idx_nx   = idx + 2'd1;
        end
      end
      ST_GAP: begin
        if (int'(cnt) == BLANK - 1) begin
          cnt_nx   = '0;
          state_nx = ST_SHOW;
          idx_nx   = idx + 2'd1;
        end
      end
      default: begin
        state_nx = ST_RST;
        idx_nx   = 2'd0;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from next-cycle values so they line up with the
  // state they describe, including a display swap at the boundary edge.
  always_comb begin
    boundary = is_last(state, idx, cnt);
    disp_nx  = (boundary && pend_full) ? pend    : disp;
    dp_nx    = (boundary && pend_full) ? pend_dp : dp;
    nibble   = disp_nx[{idx_nx, 2'b00} +: 4];
  end

  seg_hex_decoder u_dec (
    .digit (nibble),
    .seg   (seg_a2g)
  );

  always_comb begin
    case (idx_nx)
      2'd1:    lz = (disp_nx[15:4]  == 12'h000);
      2'd2:    lz = (disp_nx[15:8]  == 8'h00);
      2'd3:    lz = (disp_nx[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
    com_nx  = COM_OFF;
    data_nx = SEG_OFF;
    if (state_nx == ST_SHOW) begin
      com_nx  = ~(4'b0001 << idx_nx);
      data_nx = {(blank_lz && lz) ? 7'd0 : seg_a2g, dp_nx[idx_nx]};
    end
    fd_nx = is_last(state_nx, idx_nx, cnt_nx);
  end

  always_ff @(posedge clk_1k or negedge resetn) begin
    if (!resetn) begin
      seg_com    <= COM_OFF;
      seg_data   <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      seg_com    <= com_nx;
      seg_data   <= data_nx;
      frame_done <= fd_nx;
    end
  end

  // A pending value can only be consumed while wr_ready is low, so consume
  // and capture never coincide.
  always_ff @(posedge clk_1k or negedge resetn) begin
    if (!resetn) begin
      disp      <= 16'h0000;
      dp        <= 4'b0000;
      pend      <= 16'h0000;
      pend_dp   <= 4'b0000;
      pend_full <= 1'b0;
    end else begin
      disp <= disp_nx;
      dp   <= dp_nx;
      if (boundary && pend_full) begin
        pend_full <= 1'b0;
      end else if (wr_valid && !pend_full) begin
        pend      <= wr_data;
        pend_dp   <= wr_dp;
        pend_full <= 1'b1;
      end
    end
  end

  assign wr_ready = ~pend_full;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display on the 1 kHz clock domain. It accepts a 4-digit hex value plus decimal points from a writer via a valid/ready handshake. The value is double-buffered and applied only at frame boundaries. The block sequences one common line at a time with a programmable dwell and inter-digit blanking gap. It sits between application logic and the seg_com/seg_data pins.

Parameters:
DWELL, 4, clock cycles each digit is lit (≥1)
BLANK, 1, all-off clock cycles between digits (0 = no gap)

Ports:
clk_1k  input  1  system clock, 1 kHz
resetn  input  1  asynchronous, active-low reset
wr_valid  input  1  writer presents new display value
wr_ready  output  1  block can accept a value (pending buffer empty)
wr_data  input  16  four hex digits; [3:0]=digit0 (rightmost) … [15:12]=digit3
wr_dp  input  4  decimal point per digit, bit i = digit i
blank_lz  input  1  static; 1 = suppress leading zeros
seg_com  output  4  digit commons, active-low; bit i selects digit i
seg_data  output  8  segments active-high, {a,b,c,d,e,f,g,dp} = [7:0]
frame_done  output  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- One clock (clk_1k). Reset is asynchronous and active-low (resetn); all state clears immediately on resetn=0.
- Reset values:
  - seg_com=4'b1111, seg_data=8'h00, wr_ready=1, frame_done=0.
  - Display register=16'h0000, dp=4'b0000, pending buffer empty.
  - FSM=RST, digit index=0, counters=0.
- FSM states: RST, SHOW, GAP. All outputs are registered and reflect the current state.
- RST -> SHOW(digit 0) on the first clk_1k edge with resetn=1.
- SHOW(i):
  - seg_com = ~(4'b0001<<i); seg_data = decode(nibble i) | dp[i].
  - Held DWELL cycles.
  - Then GAP if BLANK>0, else SHOW((i+1) mod 4).
- GAP: seg_com=4'b1111, seg_data=8'h00 for BLANK cycles, then SHOW((i+1) mod 4).
- Scan order 0,1,2,3,0,… Frame length = 4*(DWELL+BLANK) cycles.
- Frame boundary = last cycle of digit 3 (last GAP cycle, or last SHOW cycle if BLANK=0).
  - frame_done=1 on exactly that cycle.
  - If pending is full, display/dp load from pending on that edge and pending clears.
  - Digit 0 of the next frame shows the new value.
- Handshake:
  - wr_ready = ~pending_full, registered.
  - Transfer occurs when wr_valid && wr_ready at an edge; wr_data/wr_dp are captured into pending and wr_ready drops the next cycle.
  - wr_valid with wr_ready=0 is ignored (no capture, no queueing).
  - A transfer in the frame-boundary cycle itself is captured but waits for the next boundary.
  - wr_ready returns to 1 the cycle after the boundary that consumes pending.
- Decode (hex, active-high):
  - 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0
  - 8=FE 9=F6 A=EE b=3E C=9C d=7A E=9E F=8E
- Leading-zero suppression (blank_lz=1):
  - Digit k (k=3,2,1) is blank (segments 00, dp still applied) if it and all higher digits are 0.
  - Digit 0 is never blanked.
  - Common lines still scan normally.
- Reset mid-operation: outputs return to reset values asynchronously; pending and display contents are lost.

Decomposition:
- Shared package seg_pkg:
  - state encoding (RST/SHOW/GAP)
  - the 16 segment-code constants
  - SEG_OFF=8'h00, COM_OFF=4'b1111
- Sub-module seg_hex_decoder: combinational 4-bit -> 7-segment, {a..g} = [7:1].
- The FSM, counters, handshake and buffering live in seg_scan_ctrl.

Test Plan:
1. Reset release (DWELL=4, BLANK=1) -> during reset 1111/00, wr_ready=1. First edge: seg_com=1110, seg_data=FC for 4 cycles, 1 gap cycle 1111/00, then 1101/FC. frame_done every 20 cycles.
2. Write wr_data=16'h1234, wr_dp=4'b0001 mid-frame -> wr_ready=0 next cycle; current frame unchanged. Next frame: digit0=67, digit1=F2, digit2=DA, digit3=60. wr_ready=1 the cycle after frame_done.
3. Second wr_valid while wr_ready=0 (data 16'hFFFF) -> ignored. After the boundary, a new write of 16'hF00F yields digit0=8E, digit1=FC, digit2=FC, digit3=8E.
4. blank_lz=1, data 16'h0050 -> digit3=00, digit2=00, digit1=B6, digit0=FC. Data 16'h0000 -> only digit0 shows FC. dp bit set on blanked digit3 -> seg_data=01.
5. resetn pulsed low mid-SHOW with pending full -> outputs immediately 1111/00, wr_ready=1. After release the display shows 0000 (FC on every digit).
6. BLANK=0 build -> no all-off cycles, frame_done period 16 cycles, SHOW(3) -> SHOW(0) directly.
